// File: rtl/fir_out_pkg.sv
// rtl/fir_out_pkg.sv - shared types and constants for the FIR output controller
package fir_out_pkg;

  localparam int ACC_W   = 40;
  localparam int OUT_W   = 16;
  localparam int COE_W   = 16;
  localparam int NCH_DEF = 4;
  localparam int GAIN_W  = 3;

  localparam logic [OUT_W-1:0] SAT_POS = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic [OUT_W-1:0] SAT_NEG = {1'b1, {(OUT_W-1){1'b0}}};

  typedef enum logic {IDLE, SEND} state_t;
  typedef logic [1:0]        ch_t;
  typedef logic [GAIN_W-1:0] gain_t;

endpackage

// File: rtl/fir_out_scale.sv
// rtl/fir_out_scale.sv - one channel: gain shift, round half up, saturate, registered
module fir_out_scale
  import fir_out_pkg::*;
#(
  parameter int ACCBITWIDTH = ACC_W,
  parameter int OUTBITWIDTH = OUT_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [ACCBITWIDTH-1:0] acc,
  input  gain_t                  gain,
  output logic [OUTBITWIDTH-1:0] sample,
  output logic                   sat
);

  localparam int LSB = ACCBITWIDTH - OUTBITWIDTH;
  localparam logic [OUTBITWIDTH-1:0] SAT_P = {1'b0, {(OUTBITWIDTH-1){1'b1}}};
  localparam logic [OUTBITWIDTH-1:0] SAT_N = {1'b1, {(OUTBITWIDTH-1){1'b0}}};

  logic [ACCBITWIDTH-1:0] shifted;
  logic [OUTBITWIDTH-1:0] trunc;
  logic                   round_bit;
  logic                   pre_ovf;
  logic                   rnd_ovf;
  logic                   unused_low_bits;

  assign shifted         = acc << gain;
  assign trunc           = shifted[ACCBITWIDTH-1:LSB];
  assign round_bit       = shifted[LSB-1];
  assign unused_low_bits = ^shifted[LSB-2:0];
  assign rnd_ovf         = (trunc == SAT_P) && round_bit;

  // Bits shifted out above the sign must all equal the sign, else the value overflowed.
  always_comb begin
    pre_ovf = 1'b0;
    for (int i = 1; i < (1 << GAIN_W); i++) begin
      if (i <= int'(gain) && acc[ACCBITWIDTH-1-i] != acc[ACCBITWIDTH-1]) begin
        pre_ovf = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sample <= '0;
      sat    <= 1'b0;
    end else if (pre_ovf || rnd_ovf) begin
      sample <= acc[ACCBITWIDTH-1] ? SAT_N : SAT_P;
      sat    <= 1'b1;
    end else begin
      sample <= trunc + OUTBITWIDTH'(round_bit);
      sat    <= 1'b0;
    end
  end

endmodule

// File: rtl/fir_out_cntrl.sv
// rtl/fir_out_cntrl.sv - scales four FIR accumulators and serializes them through a two-frame buffer
module fir_out_cntrl
  import fir_out_pkg::*;
#(
  parameter int ACCBITWIDTH = ACC_W,
  parameter int OUTBITWIDTH = OUT_W,
  parameter int COEBITWIDTH = COE_W,
  parameter int NCH         = NCH_DEF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NCH*ACCBITWIDTH-1:0] acc_data,
  input  logic                       acc_valid,
  input  logic                       gain_indicator,
  input  logic [COEBITWIDTH-1:0]     gain_param,
  input  logic                       config_sync,
  output logic [OUTBITWIDTH-1:0]     dout,
  output logic [1:0]                 dout_chan,
  output logic                       dout_valid,
  input  logic                       dout_ready,
  output logic                       sat_flag,
  output logic                       overrun
);

  gain_t shadow_gain;
  gain_t active_gain;
  logic  unused_gain_bits;

  logic [OUTBITWIDTH-1:0] scaled [NCH];
  logic [NCH-1:0]         scaled_sat;
  logic                   scaled_valid;

  logic [OUTBITWIDTH-1:0] fb_data [2][NCH];
  logic [NCH-1:0]         fb_sat  [2];
  logic [1:0]             fb_full;
  logic                   wr_ptr;
  logic                   rd_ptr;

  state_t state;
  ch_t    ch;
  ch_t    nxt_ch;

  logic                   release_fr;
  logic                   wr_en;
  logic                   head;
  logic                   head_avail;
  logic [OUTBITWIDTH-1:0] head_data;
  logic                   head_sat;

  assign unused_gain_bits = ^gain_param[COEBITWIDTH-1:GAIN_W];
  assign dout_chan        = ch;

  for (genvar k = 0; k < NCH; k++) begin : g_scale
    fir_out_scale #(
      .ACCBITWIDTH(ACCBITWIDTH),
      .OUTBITWIDTH(OUTBITWIDTH)
    ) u_scale (
      .clk   (clk),
      .rst   (rst),
      .acc   (acc_data[k*ACCBITWIDTH +: ACCBITWIDTH]),
      .gain  (active_gain),
      .sample(scaled[k]),
      .sat   (scaled_sat[k])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow_gain  <= '0;
      active_gain  <= '0;
      scaled_valid <= 1'b0;
    end else begin
      if (gain_indicator) shadow_gain <= gain_param[GAIN_W-1:0];
      if (config_sync)    active_gain <= shadow_gain;
      scaled_valid <= acc_valid;
    end
  end

  // A release in the same cycle frees the entry a new frame wants, so that write still lands.
  // The next frame to show may still be in flight from the scalers, hence the bypass.
  always_comb begin
    nxt_ch     = ch + 2'd1;
    release_fr = (state == SEND) && dout_ready && (ch == ch_t'(NCH-1));
    wr_en      = scaled_valid && (!fb_full[wr_ptr] || (release_fr && (rd_ptr == wr_ptr)));
    head       = (state == SEND) ? ~rd_ptr : rd_ptr;
    head_avail = fb_full[head] || (wr_en && (wr_ptr == head));
    head_data  = fb_full[head] ? fb_data[head][0] : scaled[0];
    head_sat   = fb_full[head] ? fb_sat[head][0]  : scaled_sat[0];
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int k = 0; k < NCH; k++) fb_data[wr_ptr][k] <= scaled[k];
      fb_sat[wr_ptr] <= scaled_sat;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fb_full    <= '0;
      wr_ptr     <= 1'b0;
      rd_ptr     <= 1'b0;
      overrun    <= 1'b0;
      state      <= IDLE;
      ch         <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
      sat_flag   <= 1'b0;
    end else begin
      if (scaled_valid && !wr_en) overrun <= 1'b1;
      if (release_fr) begin
        fb_full[rd_ptr] <= 1'b0;
        rd_ptr          <= ~rd_ptr;
      end
      if (wr_en) begin
        fb_full[wr_ptr] <= 1'b1;
        wr_ptr          <= ~wr_ptr;
      end

      case (state)
        IDLE: begin
          if (head_avail) begin
            state      <= SEND;
            ch         <= '0;
            dout       <= head_data;
            sat_flag   <= head_sat;
            dout_valid <= 1'b1;
          end
        end
        SEND: begin
          if (dout_ready) begin
            if (ch != ch_t'(NCH-1)) begin
              ch       <= nxt_ch;
              dout     <= fb_data[rd_ptr][nxt_ch];
              sat_flag <= fb_sat[rd_ptr][nxt_ch];
            end else if (head_avail) begin
              ch       <= '0;
              dout     <= head_data;
              sat_flag <= head_sat;
            end else begin
              state      <= IDLE;
              ch         <= '0;
              dout       <= '0;
              sat_flag   <= 1'b0;
              dout_valid <= 1'b0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fir_out_cntrl.sv
// tb/tb_fir_out_cntrl.sv - self-checking bench for fir_out_cntrl
module tb_fir_out_cntrl;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [159:0]   acc_data = '0;
  logic           acc_valid = 1'b0;
  logic           gain_indicator = 1'b0;
  logic [15:0]    gain_param = '0;
  logic           config_sync = 1'b0;
  logic           dout_ready = 1'b0;
  logic [15:0]    dout;
  logic [1:0]     dout_chan;
  logic           dout_valid;
  logic           sat_flag;
  logic           overrun;

  always #5 clk = ~clk;

  fir_out_cntrl dut (
    .clk           (clk),
    .rst           (rst),
    .acc_data      (acc_data),
    .acc_valid     (acc_valid),
    .gain_indicator(gain_indicator),
    .gain_param    (gain_param),
    .config_sync   (config_sync),
    .dout          (dout),
    .dout_chan     (dout_chan),
    .dout_valid    (dout_valid),
    .dout_ready    (dout_ready),
    .sat_flag      (sat_flag),
    .overrun       (overrun)
  );

  typedef struct {
    logic [15:0] data;
    logic [1:0]  chan;
    logic        sat;
  } sb_t;

  typedef struct {
    logic [3:0][39:0] acc;
    int               g;
    logic [3:0][15:0] exp;
    logic [3:0]       sat;
  } vec_t;

  sb_t  sb_q[$];
  vec_t vecs[3];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   model_g = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h expected=%0h", name, got, exp);
    end
  endtask

  task automatic sb_check();
    sb_t e;
    if (!rst && dout_valid && dout_ready) begin
      if (sb_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL sb_extra got dout=%0h chan=%0d expected no sample", dout, dout_chan);
      end else begin
        e = sb_q.pop_front();
        chk("sb_data", dout, e.data);
        chk("sb_chan", dout_chan, e.chan);
        chk("sb_sat", sat_flag, e.sat);
      end
    end
  endtask

  task automatic cyc();
    @(negedge clk);
    sb_check();
    @(posedge clk);
    #1;
  endtask

  function automatic void model(input logic [39:0] acc, input int g,
                                output logic [15:0] d, output logic s);
    longint v;
    longint q;
    v = longint'($signed(acc)) * (longint'(1) << g);
    q = (v + (longint'(1) << 23)) >>> 24;
    s = (v > (longint'(1) << 39) - 1) || (v < -(longint'(1) << 39)) ||
        (q > 32767) || (q < -32768);
    if (s) d = (v < 0) ? 16'h8000 : 16'h7FFF;
    else   d = q[15:0];
  endfunction

  function automatic logic [39:0] rnd_acc();
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    return 40'($signed(r[39:0]) >>> $urandom_range(0, 16));
  endfunction

  task automatic push_frame(input logic [3:0][15:0] exp, input logic [3:0] sat);
    for (int k = 0; k < 4; k++) sb_q.push_back('{exp[k], 2'(k), sat[k]});
  endtask

  task automatic push_model(input logic [3:0][39:0] a);
    logic [15:0] d;
    logic        s;
    for (int k = 0; k < 4; k++) begin
      model(a[k], model_g, d, s);
      sb_q.push_back('{d, 2'(k), s});
    end
  endtask

  task automatic send(input logic [3:0][39:0] a);
    acc_data  = a;
    acc_valid = 1'b1;
    cyc();
    acc_valid = 1'b0;
  endtask

  task automatic set_gain(input int g);
    gain_indicator = 1'b1;
    gain_param     = 16'(g);
    cyc();
    gain_indicator = 1'b0;
    config_sync    = 1'b1;
    cyc();
    config_sync    = 1'b0;
    model_g        = g;
  endtask

  task automatic drain();
    for (int i = 0; i < 60; i++) begin
      if (sb_q.size() == 0 && !dout_valid) break;
      cyc();
    end
    chk("drain_left", sb_q.size(), 0);
    chk("drain_valid", dout_valid, 1'b0);
  endtask

  initial begin
    logic [3:0][39:0] f1;
    logic [3:0][39:0] f2;
    logic [3:0][39:0] f3;

    vecs[0] = '{acc: {40'h0, 40'hFFFF000000, 40'h0001000000, 40'h0000800000}, g: 0,
                exp: {16'h0000, 16'hFFFF, 16'h0001, 16'h0001}, sat: 4'b0000};
    vecs[1] = '{acc: {40'h0, 40'h0020000000, 40'hA000000000, 40'h4000000000}, g: 1,
                exp: {16'h0000, 16'h0040, 16'h8000, 16'h7FFF}, sat: 4'b0011};
    vecs[2] = '{acc: {40'h7FFF7FFFFF, 40'h8000000000, 40'hFFFFFFFFFF, 40'h7FFF800000}, g: 0,
                exp: {16'h7FFF, 16'h8000, 16'h0000, 16'h7FFF}, sat: 4'b0001};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_dout", dout, 16'h0);
    chk("rst_chan", dout_chan, 2'd0);
    chk("rst_valid", dout_valid, 1'b0);
    chk("rst_sat", sat_flag, 1'b0);
    chk("rst_overrun", overrun, 1'b0);
    rst = 1'b0;
    cyc();
    dout_ready = 1'b1;

    for (int i = 0; i < 3; i++) begin
      if (vecs[i].g != model_g) set_gain(vecs[i].g);
      push_frame(vecs[i].exp, vecs[i].sat);
      send(vecs[i].acc);
      chk("lat_n1_valid", dout_valid, 1'b0);
      cyc();
      chk("lat_n2_valid", dout_valid, 1'b1);
      chk("lat_n2_chan", dout_chan, 2'd0);
      drain();
    end

    // Shadow loads g=2; config_sync alongside acc_valid must still scale with the old gain.
    set_gain(0);
    gain_indicator = 1'b1;
    gain_param     = 16'hFFF2;
    cyc();
    gain_indicator = 1'b0;
    for (int k = 0; k < 4; k++) f1[k] = rnd_acc();
    push_model(f1);
    config_sync = 1'b1;
    send(f1);
    config_sync = 1'b0;
    model_g = 2;
    drain();
    push_model(f1);
    send(f1);
    drain();

    set_gain(int'($urandom_range(0, 7)));
    for (int n = 0; n < 8; n++) begin
      for (int k = 0; k < 4; k++) f1[k] = rnd_acc();
      push_model(f1);
      send(f1);
      repeat (3) cyc();
    end
    drain();
    chk("stream_overrun", overrun, 1'b0);

    set_gain(0);
    push_frame(vecs[0].exp, vecs[0].sat);
    send(vecs[0].acc);
    for (int i = 0; i < 10 && !(dout_valid && dout_chan == 2'd2); i++) cyc();
    chk("hold_reach_chan", dout_chan, 2'd2);
    dout_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk("hold_valid", dout_valid, 1'b1);
      chk("hold_chan", dout_chan, 2'd2);
      chk("hold_data", dout, 16'hFFFF);
    end
    dout_ready = 1'b1;
    drain();

    dout_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      f1[k] = rnd_acc();
      f2[k] = rnd_acc();
      f3[k] = rnd_acc();
    end
    push_model(f1);
    push_model(f2);
    acc_data  = f1;
    acc_valid = 1'b1;
    cyc();
    acc_data = f2;
    cyc();
    acc_data = f3;
    cyc();
    acc_valid = 1'b0;
    chk("ovr_before", overrun, 1'b0);
    cyc();
    chk("ovr_after", overrun, 1'b1);
    dout_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk("b2b_valid", dout_valid, 1'b1);
      cyc();
    end
    chk("b2b_end_valid", dout_valid, 1'b0);
    chk("b2b_left", sb_q.size(), 0);
    chk("ovr_sticky", overrun, 1'b1);

    push_frame(vecs[0].exp, vecs[0].sat);
    send(vecs[0].acc);
    for (int i = 0; i < 10 && !(dout_valid && dout_chan == 2'd1); i++) cyc();
    chk("rst_mid_chan", dout_chan, 2'd1);
    rst = 1'b1;
    #1;
    chk("rst_mid_valid", dout_valid, 1'b0);
    chk("rst_mid_overrun", overrun, 1'b0);
    chk("rst_mid_chan0", dout_chan, 2'd0);
    sb_q.delete();
    cyc();
    cyc();
    rst = 1'b0;
    model_g = 0;
    cyc();
    push_frame(vecs[0].exp, vecs[0].sat);
    send(vecs[0].acc);
    chk("restart_n1_valid", dout_valid, 1'b0);
    cyc();
    chk("restart_valid", dout_valid, 1'b1);
    chk("restart_chan", dout_chan, 2'd0);
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

endmodule
